// File: rtl/song_score_ctrl.sv
// song_score_ctrl
//   Scores a sung performance note by note. For each note of the reference
//   melody it fetches the reference pitch from the melody ROM, listens to the
//   pitch detector for NOTE_TICKS cycles (last valid sample wins), issues one
//   start pulse to the comparison scorer, and adds the returned per-note score
//   into a song total. Rests (ROM value 0) skip the compare and score 0.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   play                  : start a song (accepted only when idle)
//   freq_valid, sung_freq : pitch detector strobe and frequency (Hz)
//   rom_addr, rom_freq    : melody ROM address / data (data one cycle later)
//   cmp_enable, cmp_start : enable and one-cycle start pulse to the scorer
//   cmp_sung_freq         : sung frequency operand (stable through compare)
//   cmp_ref_freq          : reference frequency operand (stable through compare)
//   cmp_score             : score from the scorer, sampled CMP_LATENCY cycles
//                           after the start pulse
//   busy, note_idx        : song in progress / note being processed
//   note_done, note_score : per-note pulse and that note's score (held)
//   done, total_score     : song-complete pulse and accumulated score (held)
module song_score_ctrl #(
  parameter int NUM_NOTES   = 16,
  parameter int NOTE_TICKS  = 1024,
  parameter int CMP_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        freq_valid,
  input  logic [14:0] sung_freq,
  output logic [7:0]  rom_addr,
  input  logic [14:0] rom_freq,
  output logic        cmp_enable,
  output logic        cmp_start,
  output logic [14:0] cmp_sung_freq,
  output logic [14:0] cmp_ref_freq,
  input  logic [3:0]  cmp_score,
  output logic        busy,
  output logic [7:0]  note_idx,
  output logic        note_done,
  output logic [3:0]  note_score,
  output logic        done,
  output logic [11:0] total_score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_LISTEN,
    S_COMPARE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam int TICK_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam int LAT_W  = (CMP_LATENCY > 1) ? $clog2(CMP_LATENCY) : 1;
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(NOTE_TICKS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(CMP_LATENCY - 1);
  localparam logic [7:0]        LAST_IDX  = 8'(NUM_NOTES - 1);

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [14:0]       ref_reg;
  logic [14:0]       sung_reg;
  logic [3:0]        note_pts;

  // ROM is addressed directly by the note index; note_idx only changes on the
  // edge entering FETCH, so the address is stable for the ROM read.
  assign rom_addr      = note_idx;
  assign cmp_enable    = busy;
  assign cmp_ref_freq  = ref_reg;
  assign cmp_sung_freq = sung_reg;

  // ref_reg is untouched between LOAD and the next LOAD, so it still marks a
  // rest when the note reaches ACCUM.
  always_comb begin
    note_pts = '0;
    if (ref_reg != '0) note_pts = cmp_score;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      lat_cnt     <= '0;
      ref_reg     <= '0;
      sung_reg    <= '0;
      cmp_start   <= 1'b0;
      busy        <= 1'b0;
      note_idx    <= '0;
      note_done   <= 1'b0;
      note_score  <= '0;
      done        <= 1'b0;
      total_score <= '0;
    end else begin
      cmp_start <= 1'b0;
      note_done <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (play) begin
            note_idx    <= '0;
            total_score <= '0;
            note_score  <= '0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ref_reg  <= rom_freq;
          sung_reg <= '0;
          tick_cnt <= TICK_LOAD;
          state    <= S_LISTEN;
        end
        S_LISTEN: begin
          if (freq_valid) sung_reg <= sung_freq;
          if (tick_cnt == '0) begin
            if (ref_reg == '0) begin
              state <= S_ACCUM;
            end else begin
              cmp_start <= 1'b1;
              lat_cnt   <= LAT_LOAD;
              state     <= S_COMPARE;
            end
          end else begin
            tick_cnt <= tick_cnt - 1'b1;
          end
        end
        S_COMPARE: begin
          if (lat_cnt == '0) state <= S_ACCUM;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        S_ACCUM: begin
          note_score  <= note_pts;
          total_score <= total_score + {8'b0, note_pts};
          note_done   <= 1'b1;
          if (note_idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            note_idx <= note_idx + 8'd1;
            state    <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_score_ctrl.sv
// Directed bench for song_score_ctrl: one 4-note instance (NOTE_TICKS=8,
// CMP_LATENCY=2) for sequencing/rest/reset behaviour and one 256-note
// instance (NOTE_TICKS=1) for full-scale accumulation.
module tb_song_score_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, play, freq_valid;
  logic [14:0] sung_freq, rom_freq;
  logic [7:0]  rom_addr, note_idx;
  logic        cmp_enable, cmp_start, busy, note_done, done;
  logic [14:0] cmp_sung_freq, cmp_ref_freq;
  logic [3:0]  cmp_score, note_score;
  logic [11:0] total_score;

  logic        play_b, cmp_enable_b, cmp_start_b, busy_b, note_done_b, done_b;
  logic [7:0]  rom_addr_b, note_idx_b;
  logic [14:0] cmp_sung_freq_b, cmp_ref_freq_b;
  logic [3:0]  note_score_b;
  logic [11:0] total_score_b;

  song_score_ctrl #(.NUM_NOTES(4), .NOTE_TICKS(8), .CMP_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .freq_valid(freq_valid),
    .sung_freq(sung_freq), .rom_addr(rom_addr), .rom_freq(rom_freq),
    .cmp_enable(cmp_enable), .cmp_start(cmp_start),
    .cmp_sung_freq(cmp_sung_freq), .cmp_ref_freq(cmp_ref_freq),
    .cmp_score(cmp_score), .busy(busy), .note_idx(note_idx),
    .note_done(note_done), .note_score(note_score), .done(done),
    .total_score(total_score)
  );

  song_score_ctrl #(.NUM_NOTES(256), .NOTE_TICKS(1), .CMP_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .play(play_b), .freq_valid(1'b0),
    .sung_freq(15'd0), .rom_addr(rom_addr_b), .rom_freq(15'd100),
    .cmp_enable(cmp_enable_b), .cmp_start(cmp_start_b),
    .cmp_sung_freq(cmp_sung_freq_b), .cmp_ref_freq(cmp_ref_freq_b),
    .cmp_score(4'd15), .busy(busy_b), .note_idx(note_idx_b),
    .note_done(note_done_b), .note_score(note_score_b), .done(done_b),
    .total_score(total_score_b)
  );

  // Melody ROM with one cycle read latency.
  logic [14:0] rom [4];
  always @(posedge clk) rom_freq <= rom[rom_addr[1:0]];

  // Scorer model: score is presented only exactly two cycles after cmp_start.
  logic [3:0] score_val;
  int sc = 0;
  always @(posedge clk) begin
    if (cmp_start) sc <= 1;
    else if (sc > 0 && sc < 10) sc <= sc + 1;
  end
  assign cmp_score = (sc == 2) ? score_val : 4'd0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder (sampled mid-cycle).
  int busy_cnt = 0, done_cnt = 0, done_b_cnt = 0, nd_b_cnt = 0;
  int done_total = 0, done_b_total = 0;
  int nd_t[$];
  logic [3:0]  nd_s[$];
  logic [14:0] cs_sung[$], cs_ref[$];
  logic [7:0]  cs_idx[$];
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (note_done) begin nd_t.push_back(cyc); nd_s.push_back(note_score); end
    if (done) begin done_cnt++; done_total = int'(total_score); end
    if (cmp_start) begin
      cs_sung.push_back(cmp_sung_freq);
      cs_ref.push_back(cmp_ref_freq);
      cs_idx.push_back(note_idx);
    end
    if (note_done_b) nd_b_cnt++;
    if (done_b) begin done_b_cnt++; done_b_total = int'(total_score_b); end
  end

  int total_n = 0, bad_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"},    32'(busy), 0);
    chk({p, "_done"},    32'(done), 0);
    chk({p, "_ndone"},   32'(note_done), 0);
    chk({p, "_cstart"},  32'(cmp_start), 0);
    chk({p, "_cen"},     32'(cmp_enable), 0);
    chk({p, "_idx"},     32'(note_idx), 0);
    chk({p, "_addr"},    32'(rom_addr), 0);
    chk({p, "_nscore"},  32'(note_score), 0);
    chk({p, "_total"},   32'(total_score), 0);
    chk({p, "_csung"},   32'(cmp_sung_freq), 0);
    chk({p, "_cref"},    32'(cmp_ref_freq), 0);
  endtask

  int nd0, cs0, busy0, done0, n;

  initial begin
    // Reset with play asserted: reset must win.
    rst_n = 1'b0; play = 1'b1; play_b = 1'b0; freq_valid = 1'b0; sung_freq = '0;
    rom[0] = 15'd440; rom[1] = 15'd494; rom[2] = 15'd523; rom[3] = 15'd587;
    score_val = 4'd9;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    chk("rst_busy_b", 32'(busy_b), 0);
    play = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Basic song, last-sample-wins, play while busy, play in DONE.
    nd0 = nd_t.size(); cs0 = cs_sung.size(); busy0 = busy_cnt; done0 = done_cnt;
    play = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      case (j)
        1:  begin play = 1'b0;
                  chk("t1_busy_rise", 32'(busy), 1);
                  chk("t1_addr0", 32'(rom_addr), 0); end
        2:  begin freq_valid = 1'b1; sung_freq = 15'd999; end
        3:  freq_valid = 1'b0;
        4:  begin freq_valid = 1'b1; sung_freq = 15'd200; end
        5:  begin freq_valid = 1'b0; play = 1'b1; end
        6:  play = 1'b0;
        7:  begin freq_valid = 1'b1; sung_freq = 15'd880; end
        8:  freq_valid = 1'b0;
        11: begin freq_valid = 1'b1; sung_freq = 15'd777; end
        12: freq_valid = 1'b0;
        13: begin chk("t1_sung_accum", 32'(cmp_sung_freq), 880);
                  freq_valid = 1'b1; sung_freq = 15'd555; end
        14: begin freq_valid = 1'b0;
                  chk("t1_sung_held", 32'(cmp_sung_freq), 880);
                  chk("t1_nd0", 32'(note_done), 1);
                  chk("t1_ns0", 32'(note_score), 9);
                  chk("t1_idx1", 32'(note_idx), 1); end
        53: begin chk("t1_done", 32'(done), 1);
                  chk("t1_busy_done", 32'(busy), 0);
                  chk("t1_total", 32'(total_score), 36);
                  play = 1'b1; end
        54: play = 1'b0;
        55: chk("t1_play_in_done", 32'(busy), 0);
        60: chk("t1_total_held", 32'(total_score), 36);
        default: ;
      endcase
    end
    chk("t1_done_cnt", done_cnt - done0, 1);
    chk("t1_busy_cycles", busy_cnt - busy0, 52);
    chk("t1_nd_cnt", nd_t.size() - nd0, 4);
    chk("t1_cs_cnt", cs_sung.size() - cs0, 4);
    if (nd_t.size() - nd0 == 4 && cs_sung.size() - cs0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) chk("t1_spacing", nd_t[nd0+k] - nd_t[nd0+k-1], 13);
        chk("t1_nscore", 32'(nd_s[nd0+k]), 9);
        chk("t1_ref", 32'(cs_ref[cs0+k]), 32'(rom[k]));
        chk("t1_idx_seq", 32'(cs_idx[cs0+k]), k);
      end
      chk("t1_last_wins", 32'(cs_sung[cs0]), 880);
      chk("t1_no_sample", 32'(cs_sung[cs0+1]), 0);
    end

    // Rests.
    rom[0] = 15'd440; rom[1] = 15'd0; rom[2] = 15'd0; rom[3] = 15'd440;
    score_val = 4'd15;
    nd0 = nd_t.size(); cs0 = cs_sung.size(); busy0 = busy_cnt; done0 = done_cnt;
    play = 1'b1; @(negedge clk); play = 1'b0;
    n = 0;
    while (done_cnt == done0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t2_done_cnt", done_cnt - done0, 1);
    chk("t2_total", done_total, 30);
    chk("t2_cs_cnt", cs_sung.size() - cs0, 2);
    chk("t2_busy_cycles", busy_cnt - busy0, 48);
    chk("t2_nd_cnt", nd_t.size() - nd0, 4);
    if (nd_t.size() - nd0 == 4) begin
      chk("t2_sp1", nd_t[nd0+1] - nd_t[nd0], 11);
      chk("t2_sp2", nd_t[nd0+2] - nd_t[nd0+1], 11);
      chk("t2_sp3", nd_t[nd0+3] - nd_t[nd0+2], 13);
      chk("t2_ns1", 32'(nd_s[nd0+1]), 0);
      chk("t2_ns3", 32'(nd_s[nd0+3]), 15);
    end

    // Reset during COMPARE of note 2, then restart.
    rom[0] = 15'd440; rom[1] = 15'd494; rom[2] = 15'd523; rom[3] = 15'd587;
    score_val = 4'd9;
    done0 = done_cnt;
    play = 1'b1;
    for (int j = 1; j <= 37; j++) begin
      @(negedge clk);
      if (j == 1) play = 1'b0;
    end
    chk("t3_pre_cstart", 32'(cmp_start), 1);
    chk("t3_pre_idx", 32'(note_idx), 2);
    chk("t3_pre_total", 32'(total_score), 18);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("t3_rst");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_no_done", done_cnt - done0, 0);
    chk("t3_idle", 32'(busy), 0);
    cs0 = cs_sung.size(); done0 = done_cnt;
    play = 1'b1; @(negedge clk); play = 1'b0;
    chk("t3_restart_busy", 32'(busy), 1);
    chk("t3_restart_idx", 32'(note_idx), 0);
    n = 0;
    while (done_cnt == done0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t3_done_cnt", done_cnt - done0, 1);
    chk("t3_total", done_total, 36);
    if (cs_sung.size() > cs0) chk("t3_first_idx", 32'(cs_idx[cs0]), 0);

    // Full-scale accumulation on the 256-note instance.
    play_b = 1'b1; @(negedge clk); play_b = 1'b0;
    n = 0;
    while (done_b_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("t4_done", done_b_cnt, 1);
    chk("t4_total", done_b_total, 3840);
    chk("t4_nd_cnt", nd_b_cnt, 256);
    chk("t4_total_held", 32'(total_score_b), 3840);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
